ibex_core_controller: RTL and testbench

Main control FSM of the ibex ID stage. It sequences boot, sleep/wakeup, decode, flush, interrupt entry and debug entry/exit. It drives PC-mux selection, CSR save/restore strobes, exception cause/mtval, and the IF/ID handshake. It sits between the decoder/ID stage, the IF stage and the CSR file.

---
 rtl/ibex_core_controller_pkg.sv | 82 ++++++++
 rtl/ibex_core_controller_if.sv | 23 ++
 rtl/ibex_core_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ibex_core_controller.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_core_controller_pkg.sv
// Shared types for the ibex ID-stage controller.
// FSM states, PC mux selects, debug causes and exception causes.
package ibex_core_controller_pkg;

  typedef enum logic [3:0] {
    RESET        = 4'd0,
    BOOT_SET     = 4'd1,
    WAIT_SLEEP   = 4'd2,
    SLEEP        = 4'd3,
    FIRST_FETCH  = 4'd4,
    DECODE       = 4'd5,
    FLUSH        = 4'd6,
    IRQ_TAKEN    = 4'd7,
    DBG_TAKEN_IF = 4'd8,
    DBG_TAKEN_ID = 4'd9
  } ctrl_fsm_e;

  typedef enum logic [2:0] {
    PC_BOOT = 3'd0,
    PC_JUMP = 3'd1,
    PC_EXC  = 3'd2,
    PC_ERET = 3'd3,
    PC_DRET = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    EXC_PC_EXC     = 2'd0,
    EXC_PC_IRQ     = 2'd1,
    EXC_PC_DBD     = 2'd2,
    EXC_PC_DBG_EXC = 2'd3
  } exc_pc_sel_e;

  typedef enum logic [2:0] {
    DBG_CAUSE_NONE    = 3'd0,
    DBG_CAUSE_EBREAK  = 3'd1,
    DBG_CAUSE_HALTREQ = 3'd3,
    DBG_CAUSE_STEP    = 3'd4
  } dbg_cause_e;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam logic [5:0] EXC_CAUSE_INSN_FAULT  = 6'h01;
  localparam logic [5:0] EXC_CAUSE_ILLEGAL     = 6'h02;
  localparam logic [5:0] EXC_CAUSE_BREAKPOINT  = 6'h03;
  localparam logic [5:0] EXC_CAUSE_LOAD_FAULT  = 6'h05;
  localparam logic [5:0] EXC_CAUSE_STORE_FAULT = 6'h07;
  localparam logic [5:0] EXC_CAUSE_ECALL_U     = 6'h08;
  localparam logic [5:0] EXC_CAUSE_ECALL_M     = 6'h0B;
  localparam logic [5:0] EXC_CAUSE_IRQ_SOFT    = 6'h23;
  localparam logic [5:0] EXC_CAUSE_IRQ_TIMER   = 6'h27;
  localparam logic [5:0] EXC_CAUSE_IRQ_EXT     = 6'h2B;
  localparam logic [5:0] EXC_CAUSE_IRQ_FAST_0  = 6'h30;
  localparam logic [5:0] EXC_CAUSE_IRQ_NM      = 6'h3F;

  // Interrupt cause: NMI, then lowest fast irq, then ext, soft, timer.
  function automatic logic [5:0] irq_cause(
    input logic        nm,
    input logic [14:0] mfip,
    input logic        meip,
    input logic        msip,
    input logic        mtip
  );
    logic [5:0] c;
    c = '0;
    if (nm) begin
      c = EXC_CAUSE_IRQ_NM;
    end else if (|mfip) begin
      for (int k = 14; k >= 0; k--) begin
        if (mfip[k]) c = EXC_CAUSE_IRQ_FAST_0 + 6'(k);
      end
    end else if (meip) begin
      c = EXC_CAUSE_IRQ_EXT;
    end else if (msip) begin
      c = EXC_CAUSE_IRQ_SOFT;
    end else if (mtip) begin
      c = EXC_CAUSE_IRQ_TIMER;
    end
    return c;
  endfunction

endpackage

// File: rtl/ibex_core_controller_if.sv
// IF/ID handshake and PC-redirect bundle.
// master = controller, slave = fetch/ID side.
interface ibex_core_controller_if;
  logic       instr_valid;
  logic       instr_req;
  logic       pc_set;
  logic [2:0] pc_mux;
  logic [1:0] exc_pc_mux;
  logic       id_in_ready;
  logic       instr_valid_clear;

  modport master (
    input  instr_valid,
    output instr_req, pc_set, pc_mux, exc_pc_mux,
    output id_in_ready, instr_valid_clear
  );

  modport slave (
    output instr_valid,
    input  instr_req, pc_set, pc_mux, exc_pc_mux,
    input  id_in_ready, instr_valid_clear
  );
endinterface

// File: rtl/ibex_core_controller.sv
// ibex ID-stage control FSM: boot, sleep, decode, flush,
// interrupt entry and debug entry/exit.
module ibex_core_controller
  import ibex_core_controller_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  ibex_core_controller_if.master ctrl,
  input  logic        fetch_enable_i,
  input  logic [31:0] instr_i,
  input  logic [15:0] instr_compressed_i,
  input  logic        instr_is_compressed_i,
  input  logic        illegal_insn_i,
  input  logic        ecall_insn_i,
  input  logic        mret_insn_i,
  input  logic        dret_insn_i,
  input  logic        wfi_insn_i,
  input  logic        ebrk_insn_i,
  input  logic        csr_pipe_flush_i,
  input  logic        instr_fetch_err_i,
  input  logic        load_err_i,
  input  logic        store_err_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] lsu_addr_last_i,
  input  logic        branch_set_i,
  input  logic        jump_set_i,
  input  logic        stall_lsu_i,
  input  logic        stall_multdiv_i,
  input  logic        stall_jump_i,
  input  logic        stall_branch_i,
  input  logic        irq_pending_i,
  input  logic        irq_nm_i,
  input  logic        csr_msip_i,
  input  logic        csr_mtip_i,
  input  logic        csr_meip_i,
  input  logic [14:0] csr_mfip_i,
  input  logic        csr_mstatus_mie_i,
  input  logic        csr_mstatus_tw_i,
  input  logic [1:0]  priv_mode_i,
  input  logic        debug_req_i,
  input  logic        debug_single_step_i,
  input  logic        debug_ebreakm_i,
  input  logic        debug_ebreaku_i,
  output logic        ctrl_busy_o,
  output logic [5:0]  exc_cause_o,
  output logic [31:0] csr_mtval_o,
  output logic        csr_save_if_o,
  output logic        csr_save_id_o,
  output logic        csr_save_cause_o,
  output logic        csr_restore_mret_id_o,
  output logic        csr_restore_dret_id_o,
  output logic        debug_csr_save_o,
  output logic [2:0]  debug_cause_o,
  output logic        debug_mode_o,
  output logic        perf_jump_o,
  output logic        perf_tbranch_o
);

  ctrl_fsm_e   state_q, state_d;
  logic        debug_mode_q, debug_mode_d;
  logic        stall, halt_if, flush_id;
  logic        irq_req, special, ebrk_dbg, wfi_ill, exc;
  logic        instr_req, pc_set;
  pc_sel_e     pc_mux;
  exc_pc_sel_e exc_pc_mux;
  logic [31:0] ill_mtval;

  assign stall = stall_lsu_i | stall_multdiv_i
               | stall_jump_i | stall_branch_i;

  assign irq_req = irq_nm_i
                 | (irq_pending_i & csr_mstatus_mie_i
                    & ~debug_mode_q);

  assign special = ctrl.instr_valid
                 & (illegal_insn_i | ecall_insn_i
                    | mret_insn_i | dret_insn_i
                    | wfi_insn_i | ebrk_insn_i
                    | csr_pipe_flush_i | instr_fetch_err_i
                    | load_err_i | store_err_i);

  assign ebrk_dbg = ~debug_mode_q
                  & (((priv_mode_i == PRIV_M) & debug_ebreakm_i)
                   | ((priv_mode_i == PRIV_U) & debug_ebreaku_i));

  assign wfi_ill = (priv_mode_i == PRIV_U) & csr_mstatus_tw_i;

  assign ill_mtval = instr_is_compressed_i
                   ? {16'h0, instr_compressed_i} : instr_i;

  assign ctrl.instr_req         = instr_req;
  assign ctrl.pc_set            = pc_set;
  assign ctrl.pc_mux            = pc_mux;
  assign ctrl.exc_pc_mux        = exc_pc_mux;
  assign ctrl.id_in_ready       = ~stall & ~halt_if;
  assign ctrl.instr_valid_clear = ~stall
                                & (ctrl.id_in_ready | flush_id);
  assign debug_mode_o           = debug_mode_q;

  // State and debug-mode flag, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RESET;
      debug_mode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      debug_mode_q <= debug_mode_d;
    end
  end

  // Next state and all combinational control outputs
  always_comb begin
    state_d               = state_q;
    debug_mode_d          = debug_mode_q;
    halt_if               = 1'b0;
    flush_id              = 1'b0;
    exc                   = 1'b0;
    instr_req             = 1'b1;
    ctrl_busy_o           = 1'b1;
    pc_set                = 1'b0;
    pc_mux                = PC_BOOT;
    exc_pc_mux            = EXC_PC_EXC;
    exc_cause_o           = '0;
    csr_mtval_o           = '0;
    csr_save_if_o         = 1'b0;
    csr_save_id_o         = 1'b0;
    csr_save_cause_o      = 1'b0;
    csr_restore_mret_id_o = 1'b0;
    csr_restore_dret_id_o = 1'b0;
    debug_csr_save_o      = 1'b0;
    debug_cause_o         = DBG_CAUSE_NONE;
    perf_jump_o           = 1'b0;
    perf_tbranch_o        = 1'b0;

    unique case (state_q)
      RESET: begin
        instr_req   = 1'b0;
        ctrl_busy_o = 1'b0;
        if (fetch_enable_i) state_d = BOOT_SET;
      end

      BOOT_SET: begin
        pc_set  = 1'b1;
        pc_mux  = PC_BOOT;
        state_d = FIRST_FETCH;
      end

      WAIT_SLEEP, SLEEP: begin
        instr_req   = 1'b0;
        ctrl_busy_o = 1'b0;
        halt_if     = 1'b1;
        flush_id    = 1'b1;
        if (state_q == WAIT_SLEEP) begin
          state_d = SLEEP;
        end else if (debug_req_i | irq_pending_i
                     | irq_nm_i | debug_single_step_i) begin
          state_d = FIRST_FETCH;
        end
      end

      FIRST_FETCH: begin
        if (ctrl.id_in_ready) state_d = DECODE;
        if (irq_req) state_d = IRQ_TAKEN;
        if (debug_req_i & ~debug_mode_q) begin
          state_d = DBG_TAKEN_IF;
        end
      end

      DECODE: begin
        if (special) begin
          halt_if = 1'b1;
          state_d = FLUSH;
        end else if (branch_set_i | jump_set_i) begin
          pc_set         = 1'b1;
          pc_mux         = PC_JUMP;
          perf_tbranch_o = branch_set_i;
          perf_jump_o    = jump_set_i;
        end
        if (~stall & ~special) begin
          if ((debug_req_i | debug_single_step_i)
              & ~debug_mode_q) begin
            halt_if = 1'b1;
            state_d = DBG_TAKEN_IF;
          end else if (irq_req) begin
            halt_if = 1'b1;
            state_d = IRQ_TAKEN;
          end
        end
      end

      IRQ_TAKEN: begin
        pc_set           = 1'b1;
        pc_mux           = PC_EXC;
        exc_pc_mux       = EXC_PC_IRQ;
        csr_save_if_o    = 1'b1;
        csr_save_cause_o = 1'b1;
        exc_cause_o      = irq_cause(irq_nm_i, csr_mfip_i,
                                     csr_meip_i, csr_msip_i,
                                     csr_mtip_i);
        state_d          = DECODE;
      end

      DBG_TAKEN_IF, DBG_TAKEN_ID: begin
        pc_set           = 1'b1;
        pc_mux           = PC_EXC;
        exc_pc_mux       = EXC_PC_DBD;
        debug_csr_save_o = 1'b1;
        debug_mode_d     = 1'b1;
        state_d          = DECODE;
        if (state_q == DBG_TAKEN_ID) begin
          csr_save_id_o = 1'b1;
          debug_cause_o = DBG_CAUSE_EBREAK;
        end else begin
          csr_save_if_o = 1'b1;
          debug_cause_o = debug_single_step_i
                        ? DBG_CAUSE_STEP : DBG_CAUSE_HALTREQ;
        end
      end

      FLUSH: begin
        halt_if  = 1'b1;
        flush_id = 1'b1;
        state_d  = DECODE;
        if (instr_fetch_err_i) begin
          exc         = 1'b1;
          exc_cause_o = EXC_CAUSE_INSN_FAULT;
          csr_mtval_o = pc_id_i;
        end else if (illegal_insn_i) begin
          exc         = 1'b1;
          exc_cause_o = EXC_CAUSE_ILLEGAL;
          csr_mtval_o = ill_mtval;
        end else if (ecall_insn_i) begin
          exc         = 1'b1;
          exc_cause_o = (priv_mode_i == PRIV_M)
                      ? EXC_CAUSE_ECALL_M : EXC_CAUSE_ECALL_U;
        end else if (ebrk_insn_i) begin
          if (ebrk_dbg) begin
            state_d = DBG_TAKEN_ID;
          end else begin
            exc         = 1'b1;
            exc_cause_o = EXC_CAUSE_BREAKPOINT;
          end
        end else if (store_err_i) begin
          exc         = 1'b1;
          exc_cause_o = EXC_CAUSE_STORE_FAULT;
          csr_mtval_o = lsu_addr_last_i;
        end else if (load_err_i) begin
          exc         = 1'b1;
          exc_cause_o = EXC_CAUSE_LOAD_FAULT;
          csr_mtval_o = lsu_addr_last_i;
        end else if (mret_insn_i) begin
          pc_set                = 1'b1;
          pc_mux                = PC_ERET;
          csr_restore_mret_id_o = 1'b1;
        end else if (dret_insn_i) begin
          pc_set                = 1'b1;
          pc_mux                = PC_DRET;
          csr_restore_dret_id_o = 1'b1;
          debug_mode_d          = 1'b0;
        end else if (wfi_insn_i & ~debug_mode_q) begin
          if (wfi_ill) begin
            exc         = 1'b1;
            exc_cause_o = EXC_CAUSE_ILLEGAL;
            csr_mtval_o = ill_mtval;
          end else begin
            state_d = WAIT_SLEEP;
          end
        end
        // Exceptions taken in debug mode stay out of the M-mode CSRs
        if (exc) begin
          pc_set           = 1'b1;
          pc_mux           = PC_EXC;
          exc_pc_mux       = debug_mode_q
                           ? EXC_PC_DBG_EXC : EXC_PC_EXC;
          csr_save_id_o    = ~debug_mode_q;
          csr_save_cause_o = ~debug_mode_q;
        end
      end

      default: state_d = RESET;
    endcase
  end

endmodule

// File: tb/tb_ibex_core_controller.sv
// Bench for ibex_core_controller: directed walk-through, then
// random stimulus against a behavioural model of the controller.
module tb_ibex_core_controller;

  localparam int S_RST = 0, S_BOOT = 1, S_WSLP = 2, S_SLP = 3;
  localparam int S_FF = 4, S_DEC = 5, S_FLUSH = 6, S_IRQ = 7;
  localparam int S_DBGIF = 8, S_DBGID = 9;

  logic clk = 1'b0;
  logic rst;
  logic fetch_en;
  logic [31:0] instr;
  logic [15:0] instr_c;
  logic is_comp;
  logic illegal, ecall, mret, dret, wfi, ebrk, csr_flush;
  logic fetch_err, load_err, store_err;
  logic [31:0] pc_id, lsu_addr;
  logic branch_set, jump_set;
  logic st_lsu, st_md, st_jmp, st_br;
  logic irq_pend, irq_nm, msip, mtip, meip;
  logic [14:0] mfip;
  logic mie, tw;
  logic [1:0] priv;
  logic dbg_req, dbg_step, ebreakm, ebreaku;

  logic ctrl_busy;
  logic [5:0] exc_cause;
  logic [31:0] mtval;
  logic save_if, save_id, save_cause;
  logic rest_mret, rest_dret, dbg_csr_save;
  logic [2:0] dbg_cause;
  logic dbg_mode, perf_jump, perf_tbranch;

  int n_chk = 0;
  int n_fail = 0;

  int ph, n_ph;
  bit dbg, n_dbg;
  logic [31:0] e_busy, e_req, e_pcset, e_rdy, e_vclr;
  logic [31:0] e_pcmux, e_excmux, e_cause, e_mtval;
  logic [31:0] e_sif, e_sid, e_scause, e_rmret, e_rdret;
  logic [31:0] e_dsave, e_dcause, e_pj, e_pb;

  ibex_core_controller_if ctrl ();

  ibex_core_controller dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .ctrl                  (ctrl),
    .fetch_enable_i        (fetch_en),
    .instr_i               (instr),
    .instr_compressed_i    (instr_c),
    .instr_is_compressed_i (is_comp),
    .illegal_insn_i        (illegal),
    .ecall_insn_i          (ecall),
    .mret_insn_i           (mret),
    .dret_insn_i           (dret),
    .wfi_insn_i            (wfi),
    .ebrk_insn_i           (ebrk),
    .csr_pipe_flush_i      (csr_flush),
    .instr_fetch_err_i     (fetch_err),
    .load_err_i            (load_err),
    .store_err_i           (store_err),
    .pc_id_i               (pc_id),
    .lsu_addr_last_i       (lsu_addr),
    .branch_set_i          (branch_set),
    .jump_set_i            (jump_set),
    .stall_lsu_i           (st_lsu),
    .stall_multdiv_i       (st_md),
    .stall_jump_i          (st_jmp),
    .stall_branch_i        (st_br),
    .irq_pending_i         (irq_pend),
    .irq_nm_i              (irq_nm),
    .csr_msip_i            (msip),
    .csr_mtip_i            (mtip),
    .csr_meip_i            (meip),
    .csr_mfip_i            (mfip),
    .csr_mstatus_mie_i     (mie),
    .csr_mstatus_tw_i      (tw),
    .priv_mode_i           (priv),
    .debug_req_i           (dbg_req),
    .debug_single_step_i   (dbg_step),
    .debug_ebreakm_i       (ebreakm),
    .debug_ebreaku_i       (ebreaku),
    .ctrl_busy_o           (ctrl_busy),
    .exc_cause_o           (exc_cause),
    .csr_mtval_o           (mtval),
    .csr_save_if_o         (save_if),
    .csr_save_id_o         (save_id),
    .csr_save_cause_o      (save_cause),
    .csr_restore_mret_id_o (rest_mret),
    .csr_restore_dret_id_o (rest_dret),
    .debug_csr_save_o      (dbg_csr_save),
    .debug_cause_o         (dbg_cause),
    .debug_mode_o          (dbg_mode),
    .perf_jump_o           (perf_jump),
    .perf_tbranch_o        (perf_tbranch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic quiet();
    rst = 0; fetch_en = 1; instr = 32'h0; instr_c = 16'h0;
    is_comp = 0; illegal = 0; ecall = 0; mret = 0; dret = 0;
    wfi = 0; ebrk = 0; csr_flush = 0; fetch_err = 0;
    load_err = 0; store_err = 0; pc_id = 32'h0; lsu_addr = 32'h0;
    branch_set = 0; jump_set = 0; st_lsu = 0; st_md = 0;
    st_jmp = 0; st_br = 0; irq_pend = 0; irq_nm = 0; msip = 0;
    mtip = 0; meip = 0; mfip = '0; mie = 0; tw = 0;
    priv = 2'b11; dbg_req = 0; dbg_step = 0; ebreakm = 0;
    ebreaku = 0; ctrl.instr_valid = 0;
  endtask

  // Behavioural view: what the controller must do this cycle.
  task automatic model_eval();
    bit stall, irqreq, halt, flush, spec, take_exc;
    bit ev[9];
    int first;
    logic [14:0] low;
    logic [31:0] ill;
    stall  = st_lsu | st_md | st_jmp | st_br;
    irqreq = irq_nm | (irq_pend & mie & !dbg);
    ill    = is_comp ? {16'h0, instr_c} : instr;
    halt = 0; flush = 0; take_exc = 0;
    e_busy = 1; e_req = 1; e_pcset = 0; e_pcmux = 0;
    e_excmux = 0; e_cause = 0; e_mtval = 0; e_sif = 0;
    e_sid = 0; e_scause = 0; e_rmret = 0; e_rdret = 0;
    e_dsave = 0; e_dcause = 0; e_pj = 0; e_pb = 0;
    n_ph = ph; n_dbg = dbg;
    case (ph)
      S_RST: begin
        e_busy = 0; e_req = 0;
        if (fetch_en) n_ph = S_BOOT;
      end
      S_BOOT: begin e_pcset = 1; n_ph = S_FF; end
      S_WSLP, S_SLP: begin
        e_busy = 0; e_req = 0; halt = 1; flush = 1;
        if (ph == S_WSLP) n_ph = S_SLP;
        else if (dbg_req | irq_pend | irq_nm | dbg_step)
          n_ph = S_FF;
      end
      S_FF: begin
        if (!stall) n_ph = S_DEC;
        if (irqreq) n_ph = S_IRQ;
        if (dbg_req && !dbg) n_ph = S_DBGIF;
      end
      S_DEC: begin
        spec = ctrl.instr_valid && (illegal | ecall | mret | dret
               | wfi | ebrk | csr_flush | fetch_err | load_err
               | store_err);
        if (spec) begin
          halt = 1; n_ph = S_FLUSH;
        end else if (branch_set | jump_set) begin
          e_pcset = 1; e_pcmux = 1; e_pb = branch_set;
          e_pj = jump_set;
        end
        if (!stall && !spec && (dbg_req | dbg_step) && !dbg) begin
          halt = 1; n_ph = S_DBGIF;
        end else if (!stall && !spec && irqreq) begin
          halt = 1; n_ph = S_IRQ;
        end
      end
      S_IRQ: begin
        e_pcset = 1; e_pcmux = 2; e_excmux = 1; e_sif = 1;
        e_scause = 1; n_ph = S_DEC;
        low = mfip & (~mfip + 15'd1);
        if (irq_nm) e_cause = 63;
        else if (mfip != 0) e_cause = 48 + $clog2(low);
        else if (meip) e_cause = 43;
        else if (msip) e_cause = 35;
        else if (mtip) e_cause = 39;
      end
      S_DBGIF, S_DBGID: begin
        e_pcset = 1; e_pcmux = 2; e_excmux = 2; e_dsave = 1;
        n_dbg = 1; n_ph = S_DEC;
        if (ph == S_DBGID) begin e_sid = 1; e_dcause = 1; end
        else begin e_sif = 1; e_dcause = dbg_step ? 4 : 3; end
      end
      S_FLUSH: begin
        halt = 1; flush = 1; n_ph = S_DEC;
        ev = '{fetch_err, illegal, ecall, ebrk, store_err,
               load_err, mret, dret, wfi && !dbg};
        first = -1;
        for (int i = 8; i >= 0; i--) if (ev[i]) first = i;
        case (first)
          0: begin take_exc = 1; e_cause = 1; e_mtval = pc_id; end
          1: begin take_exc = 1; e_cause = 2; e_mtval = ill; end
          2: begin take_exc = 1; e_cause = (priv == 3) ? 11 : 8; end
          3: begin
            if (!dbg && ((priv == 3 && ebreakm)
                         || (priv == 0 && ebreaku)))
              n_ph = S_DBGID;
            else begin take_exc = 1; e_cause = 3; end
          end
          4: begin take_exc = 1; e_cause = 7; e_mtval = lsu_addr; end
          5: begin take_exc = 1; e_cause = 5; e_mtval = lsu_addr; end
          6: begin e_pcset = 1; e_pcmux = 3; e_rmret = 1; end
          7: begin
            e_pcset = 1; e_pcmux = 4; e_rdret = 1; n_dbg = 0;
          end
          8: begin
            if (priv == 0 && tw) begin
              take_exc = 1; e_cause = 2; e_mtval = ill;
            end else n_ph = S_WSLP;
          end
          default: ;
        endcase
        if (take_exc) begin
          e_pcset = 1; e_pcmux = 2; e_excmux = dbg ? 3 : 0;
          e_sid = !dbg; e_scause = !dbg;
        end
      end
      default: n_ph = S_RST;
    endcase
    e_rdy  = !stall && !halt;
    e_vclr = !stall && (e_rdy[0] || flush);
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    check("busy", 32'(ctrl_busy), e_busy);
    check("instr_req", 32'(ctrl.instr_req), e_req);
    check("pc_set", 32'(ctrl.pc_set), e_pcset);
    check("id_in_ready", 32'(ctrl.id_in_ready), e_rdy);
    check("valid_clear", 32'(ctrl.instr_valid_clear), e_vclr);
    check("pc_mux", 32'(ctrl.pc_mux), e_pcmux);
    check("exc_pc_mux", 32'(ctrl.exc_pc_mux), e_excmux);
    check("exc_cause", 32'(exc_cause), e_cause);
    check("mtval", mtval, e_mtval);
    check("save_if", 32'(save_if), e_sif);
    check("save_id", 32'(save_id), e_sid);
    check("save_cause", 32'(save_cause), e_scause);
    check("rest_mret", 32'(rest_mret), e_rmret);
    check("rest_dret", 32'(rest_dret), e_rdret);
    check("dbg_csr_save", 32'(dbg_csr_save), e_dsave);
    check("dbg_cause", 32'(dbg_cause), e_dcause);
    check("dbg_mode", 32'(dbg_mode), 32'(dbg));
    check("perf_jump", 32'(perf_jump), e_pj);
    check("perf_tbranch", 32'(perf_tbranch), e_pb);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin ph = S_RST; dbg = 0; end
    else begin ph = n_ph; dbg = n_dbg; end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  function automatic bit one_in(int n);
    return $urandom_range(n - 1, 0) == 0;
  endfunction

  task automatic rand_inputs();
    rst = one_in(300); fetch_en = !one_in(8);
    ctrl.instr_valid = !one_in(4);
    instr = $urandom; instr_c = 16'($urandom); is_comp = one_in(2);
    illegal = one_in(24); ecall = one_in(24); mret = one_in(24);
    dret = one_in(20); wfi = one_in(24); ebrk = one_in(20);
    csr_flush = one_in(24); fetch_err = one_in(40);
    load_err = one_in(40); store_err = one_in(40);
    pc_id = $urandom; lsu_addr = $urandom;
    branch_set = one_in(8); jump_set = one_in(8);
    st_lsu = one_in(10); st_md = one_in(10);
    st_jmp = one_in(10); st_br = one_in(10);
    irq_pend = one_in(10); irq_nm = one_in(50);
    msip = one_in(2); mtip = one_in(2); meip = one_in(2);
    mfip = one_in(3) ? 15'($urandom) : '0;
    mie = one_in(2); tw = one_in(2);
    priv = one_in(8) ? 2'($urandom_range(2, 1))
                     : (one_in(2) ? 2'b11 : 2'b00);
    dbg_req = one_in(20); dbg_step = one_in(30);
    ebreakm = one_in(2); ebreaku = one_in(2);
  endtask

  initial begin
    quiet();
    rst = 1; fetch_en = 0;
    ph = S_RST; dbg = 0;
    advance();
    settle();
    check("plan_rst_req", 32'(ctrl.instr_req), 32'h0);
    check("plan_rst_busy", 32'(ctrl_busy), 32'h0);
    advance();
    rst = 0; fetch_en = 1;
    tick();
    settle();
    check("plan_boot_pcset", 32'(ctrl.pc_set), 32'h1);
    check("plan_boot_pcmux", 32'(ctrl.pc_mux), 32'h0);
    advance();
    tick();

    ctrl.instr_valid = 1; illegal = 1; is_comp = 1;
    instr_c = 16'hABCD; instr = 32'h1234_5678;
    tick();
    settle();
    check("plan_ill_cause", 32'(exc_cause), 32'h02);
    check("plan_ill_mtval", mtval, 32'h0000_ABCD);
    check("plan_ill_pcmux", 32'(ctrl.pc_mux), 32'h2);
    check("plan_ill_excmux", 32'(ctrl.exc_pc_mux), 32'h0);
    advance();
    quiet();

    irq_pend = 1; mie = 1; meip = 1;
    tick();
    settle();
    check("plan_irq_cause", 32'(exc_cause), 32'h2B);
    check("plan_irq_saveif", 32'(save_if), 32'h1);
    check("plan_irq_excmux", 32'(ctrl.exc_pc_mux), 32'h1);
    advance();
    quiet();

    dbg_req = 1;
    tick();
    settle();
    check("plan_dbg_cause", 32'(dbg_cause), 32'h3);
    check("plan_dbg_excmux", 32'(ctrl.exc_pc_mux), 32'h2);
    advance();
    quiet();
    ctrl.instr_valid = 1; dret = 1;
    settle();
    check("plan_dbg_mode_on", 32'(dbg_mode), 32'h1);
    advance();
    settle();
    check("plan_dret_pcmux", 32'(ctrl.pc_mux), 32'h4);
    advance();
    quiet();
    settle();
    check("plan_dbg_mode_off", 32'(dbg_mode), 32'h0);
    advance();

    ctrl.instr_valid = 1; wfi = 1;
    tick();
    tick();
    quiet();
    tick();
    settle();
    check("plan_sleep_req", 32'(ctrl.instr_req), 32'h0);
    check("plan_sleep_busy", 32'(ctrl_busy), 32'h0);
    advance();
    irq_nm = 1;
    tick();
    irq_nm = 0;
    settle();
    check("plan_wake_busy", 32'(ctrl_busy), 32'h1);
    advance();
    tick();

    st_lsu = 1; branch_set = 1;
    settle();
    check("plan_stall_pcset", 32'(ctrl.pc_set), 32'h1);
    check("plan_stall_tbr", 32'(perf_tbranch), 32'h1);
    check("plan_stall_rdy", 32'(ctrl.id_in_ready), 32'h0);
    check("plan_stall_vclr", 32'(ctrl.instr_valid_clear), 32'h0);
    advance();

    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
